// File: rtl/md_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        read_hi;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  start, md_op, src_a, src_b, read_hi,
        output busy, rd_data, hi, lo
    );

    modport master (
        output start, md_op, src_a, src_b, read_hi,
        input  busy, rd_data, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/div unit: result is computed at accept time, held in pend_*,
// and committed to HI/LO after a fixed latency so the pipeline sees a plain busy window.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_r, lo_r, pend_hi, pend_lo;

    logic signed [63:0] sa64, sb64, prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        mag_a, mag_b, uq, ur, sq, sr;
    logic [31:0]        nxt_hi, nxt_lo;
    logic               is_md;

    assign is_md = (bus.md_op >= OP_MULT) && (bus.md_op <= OP_DIVU);

    always_comb begin
        sa64   = {{32{bus.src_a[31]}}, bus.src_a};
        sb64   = {{32{bus.src_b[31]}}, bus.src_b};
        prod_s = sa64 * sb64;
        prod_u = {32'd0, bus.src_a} * {32'd0, bus.src_b};
        // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        mag_a  = bus.src_a[31] ? (~bus.src_a + 32'd1) : bus.src_a;
        mag_b  = bus.src_b[31] ? (~bus.src_b + 32'd1) : bus.src_b;
        uq     = mag_a / mag_b;
        ur     = mag_a % mag_b;
        sq     = (bus.src_a[31] ^ bus.src_b[31]) ? (~uq + 32'd1) : uq;
        sr     = bus.src_a[31] ? (~ur + 32'd1) : ur;
        nxt_hi = hi_r;
        nxt_lo = lo_r;
        case (bus.md_op)
            OP_MULT:  {nxt_hi, nxt_lo} = prod_s;
            OP_MULTU: {nxt_hi, nxt_lo} = prod_u;
            OP_DIV:   if (bus.src_b != 32'd0) begin
                          nxt_hi = sr;
                          nxt_lo = sq;
                      end
            OP_DIVU:  if (bus.src_b != 32'd0) begin
                          nxt_hi = bus.src_a % bus.src_b;
                          nxt_lo = bus.src_a / bus.src_b;
                      end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    if (is_md) begin
                        // Divide-by-zero captures the current HI/LO, so the commit is a no-op.
                        pend_hi <= nxt_hi;
                        pend_lo <= nxt_lo;
                        cnt     <= (bus.md_op == OP_MULT || bus.md_op == OP_MULTU)
                                   ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        state   <= RUN;
                    end else if (bus.md_op == OP_MTHI) begin
                        hi_r <= bus.src_a;
                    end else if (bus.md_op == OP_MTLO) begin
                        lo_r <= bus.src_a;
                    end
                end
                default: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        hi_r  <= pend_hi;
                        lo_r  <= pend_lo;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign bus.rd_data = bus.read_hi ? hi_r : lo_r;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized ops against a behavioural model.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m_hi, m_lo;

    md_unit_if bus();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference: MIPS HI/LO semantics expressed with plain integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] cur);
        longint          p;
        longint unsigned pu;
        int              sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin p = longint'(sa) * longint'(sb); return p; end
            3'd2: begin pu = 64'(a) * 64'(b); return pu; end
            3'd3: begin
                if (sb == 0) return cur;
                if (a == 32'h80000000 && sb == -1) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd4: begin
                if (b == 0) return cur;
                return {a % b, a / b};
            end
            3'd5: return {a, cur[31:0]};
            3'd6: return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MC;
        if (op == 3'd3 || op == 3'd4) return DC;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
        bus.md_op = 3'd0;
    endtask

    task automatic wait_idle(output int hc);
        hc = 0;
        for (int k = 0; k < 40 && bus.busy === 1'b1; k++) begin
            tick();
            hc++;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.start = 0; bus.md_op = 0; bus.src_a = 0; bus.src_b = 0; bus.read_hi = 0;
        reset = 1'b0;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", bus.hi, bus.lo); end
        checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want 0", bus.rd_data); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mt();
        issue(3'd5, 32'h11, 32'hDEAD);
        bus.read_hi = 1'b1; #1;
        checks++; if (bus.rd_data !== 32'h11) begin errors++; $display("FAIL mthi_rd got %h want 00000011", bus.rd_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", bus.busy); end
        issue(3'd6, 32'h22, 32'h0);
        bus.read_hi = 1'b0; #1;
        checks++; if (bus.rd_data !== 32'h22) begin errors++; $display("FAIL mtlo_rd got %h want 00000022", bus.rd_data); end
        checks++; if (bus.hi !== 32'h11) begin errors++; $display("FAIL mtlo_keeps_hi got %h want 00000011", bus.hi); end
    endtask

    task automatic test_mult_neg();
        int hc;
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        checks++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin errors++; $display("FAIL mult_early_commit got %h/%h want 11/22", bus.hi, bus.lo); end
        wait_idle(hc);
        checks++; if (hc !== MC) begin errors++; $display("FAIL mult_busy_len got %0d want %0d", hc, MC); end
        checks++; if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_neg got %h/%h want ffffffff/fffffffa", bus.hi, bus.lo); end
        bus.read_hi = 1'b1; #1;
        checks++; if (bus.rd_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_mfhi got %h want ffffffff", bus.rd_data); end
    endtask

    task automatic test_multu();
        int hc;
        issue(3'd2, 32'hFFFFFFFE, 32'd3);
        wait_idle(hc);
        checks++; if (hc !== MC) begin errors++; $display("FAIL multu_busy_len got %0d want %0d", hc, MC); end
        checks++; if (bus.hi !== 32'h2 || bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu got %h/%h want 00000002/fffffffa", bus.hi, bus.lo); end
    endtask

    task automatic test_div_neg();
        int hc;
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(hc);
        checks++; if (hc !== DC) begin errors++; $display("FAIL div_busy_len got %0d want %0d", hc, DC); end
        checks++; if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg got %h/%h want ffffffff/fffffffd", bus.hi, bus.lo); end
    endtask

    task automatic test_divu();
        int hc;
        issue(3'd4, 32'd7, 32'd2);
        wait_idle(hc);
        checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd3) begin errors++; $display("FAIL divu got %h/%h want 1/3", bus.hi, bus.lo); end
    endtask

    task automatic test_div_zero();
        int hc;
        issue(3'd5, 32'h11, 32'h0);
        issue(3'd6, 32'h22, 32'h0);
        issue(3'd4, 32'd5, 32'd0);
        wait_idle(hc);
        checks++; if (hc !== DC) begin errors++; $display("FAIL divz_busy_len got %0d want %0d", hc, DC); end
        checks++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin errors++; $display("FAIL divz got %h/%h want 11/22", bus.hi, bus.lo); end
    endtask

    task automatic test_div_overflow();
        int hc;
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(hc);
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h/%h want 0/80000000", bus.hi, bus.lo); end
    endtask

    task automatic test_nop();
        issue(3'd5, 32'hA5A5, 32'h0);
        issue(3'd0, 32'h1234, 32'h5);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nop0_busy got %b want 0", bus.busy); end
        issue(3'd7, 32'h1234, 32'h5);
        checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'hA5A5) begin errors++; $display("FAIL nop7 busy %b hi %h want 0/0000a5a5", bus.busy, bus.hi); end
    endtask

    task automatic test_back_to_back();
        int hc;
        pulse_reset();
        issue(3'd1, 32'd2, 32'd3);
        issue(3'd6, 32'h55, 32'h0);
        issue(3'd3, 32'd9, 32'd3);
        wait_idle(hc);
        checks++; if (hc + 2 !== MC) begin errors++; $display("FAIL busy_ignore_len got %0d want %0d", hc + 2, MC); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd6) begin errors++; $display("FAIL busy_ignore got %h/%h want 0/6", bus.hi, bus.lo); end
        issue(3'd1, 32'd4, 32'd5);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", bus.busy); end
        wait_idle(hc);
        checks++; if (hc !== MC || bus.lo !== 32'd20) begin errors++; $display("FAIL b2b_result len %0d lo %h want %0d/14", hc, bus.lo, MC); end
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(3'd5, 32'h99, 32'h0);
        issue(3'd1, 32'd7, 32'd6);
        tick(); tick();
        reset = 1'b0; #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        bus.read_hi = 1'b1; #1;
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.rd_data !== 32'h0) begin errors++; $display("FAIL rstmid_hilo got %h/%h rd %h want 0", bus.hi, bus.lo, bus.rd_data); end
        tick();
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_late_commit got %0d bad cycles want 0", seen); end
    endtask

    task automatic test_random();
        logic [2:0]  op, op2;
        logic [31:0] a, b, want;
        logic [63:0] exp;
        int          hc, extra;
        pulse_reset();
        m_hi = 0; m_lo = 0;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = $urandom_range(0, 100); b = $urandom_range(1, 9); end
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = -$urandom_range(1, 9);
                default: ;
            endcase
            exp = ref_op(op, a, b, {m_hi, m_lo});
            issue(op, a, b);
            extra = 0;
            if (bus.busy === 1'b1 && $urandom_range(0, 1) == 1) begin
                op2 = 3'($urandom_range(1, 7));
                issue(op2, $urandom, $urandom);
                extra = 1;
            end
            wait_idle(hc);
            checks++; if (hc + extra !== lat(op)) begin errors++; $display("FAIL rnd%0d_len op %0d got %0d want %0d", i, op, hc + extra, lat(op)); end
            {m_hi, m_lo} = exp;
            checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL rnd%0d op %0d a %h b %h got %h/%h want %h/%h", i, op, a, b, bus.hi, bus.lo, m_hi, m_lo); end
            bus.read_hi = 1'($urandom_range(0, 1)); #1;
            want = bus.read_hi ? m_hi : m_lo;
            checks++; if (bus.rd_data !== want) begin errors++; $display("FAIL rnd%0d_rd got %h want %h", i, bus.rd_data, want); end
        end
    endtask

    initial begin
        test_reset();
        test_mt();
        test_mult_neg();
        test_multu();
        test_div_neg();
        test_divu();
        test_div_zero();
        test_div_overflow();
        test_nop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
